// File: rtl/trig_reg.sv
// trig_reg: WIDTH-bit register bank with D load, T toggle, serial shift and
// hold modes, clock enable, synchronous clear, serial out and edge flags.
module trig_reg #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RST_VAL   = '0,
    parameter bit                SHIFT_DIR = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sclr_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             changed_o
);

    localparam logic [1:0] MODE_LOAD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_SHIFT  = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] prev_q;
    logic             sout_q;
    logic             sout_d;

    // Next-state selection: en gates everything, sclr beats the mode
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        if (en_i) begin
            if (sclr_i) begin
                q_d = RST_VAL;
            end else begin
                case (mode_i)
                    MODE_LOAD:   q_d = d_i;
                    MODE_TOGGLE: q_d = q_q ^ d_i;
                    MODE_SHIFT: begin
                        if (SHIFT_DIR == 1'b0) begin
                            q_d    = {q_q[WIDTH-2:0], sin_i};
                            sout_d = q_q[WIDTH-1];
                        end else begin
                            q_d    = {sin_i, q_q[WIDTH-1:1]};
                            sout_d = q_q[0];
                        end
                    end
                    MODE_HOLD:   q_d = q_q;
                    default:     q_d = q_q;
                endcase
            end
        end
    end

    // State registers; previous-q copy tracks every edge, even when disabled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q    <= RST_VAL;
            prev_q <= RST_VAL;
            sout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            prev_q <= q_q;
            sout_q <= sout_d;
        end
    end

    // Edge flags come straight from two registers, so they are glitch-free
    always_comb begin
        rise_o    = q_q & ~prev_q;
        fall_o    = ~q_q & prev_q;
        changed_o = |(q_q ^ prev_q);
    end

    assign q_o    = q_q;
    assign sout_o = sout_q;

endmodule

// File: tb/tb_trig_reg.sv
// tb_trig_reg: scoreboard bench for trig_reg (WIDTH=8, RST_VAL=8'hA5,
// SHIFT_DIR=0); expectations queued with stimulus, popped after each edge.
module tb_trig_reg;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic       sclr_i;
    logic [1:0] mode_i;
    logic [7:0] d_i;
    logic       sin_i;
    logic [7:0] q_o;
    logic       sout_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;
    logic       changed_o;

    int errors = 0;
    int checks = 0;

    // q[25:18] sout[17] rise[16:9] fall[8:1] changed[0]
    logic [25:0] sb[$];
    logic [7:0]  exp_prev;

    typedef struct packed {
        logic       en;
        logic       sclr;
        logic [1:0] mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] q;
        logic       so;
    } step_t;

    trig_reg #(
        .WIDTH     (8),
        .RST_VAL   (8'hA5),
        .SHIFT_DIR (1'b0)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .sclr_i    (sclr_i),
        .mode_i    (mode_i),
        .d_i       (d_i),
        .sin_i     (sin_i),
        .q_o       (q_o),
        .sout_o    (sout_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .changed_o (changed_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic step_t mk(input logic e, input logic sc,
                                 input logic [1:0] m, input logic [7:0] dv,
                                 input logic si, input logic [7:0] eq,
                                 input logic es);
        return {e, sc, m, dv, si, eq, es};
    endfunction

    // Edge flags follow from consecutive expected q values
    task automatic expect_out(input logic [7:0] eq, input logic es);
        sb.push_back({eq, es, eq & ~exp_prev, ~eq & exp_prev,
                      |(eq ^ exp_prev)});
        exp_prev = eq;
    endtask

    task automatic cyc(input step_t s);
        en_i   = s.en;
        sclr_i = s.sclr;
        mode_i = s.mode;
        d_i    = s.d;
        sin_i  = s.sin;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        logic [25:0] got, ex;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) exp_prev = 8'hA5;
            expect_out(8'hA5, 1'b0);
            case (i)
                0: #2;
                1: begin
                    @(posedge clk_i);
                    #1;
                end
                default: begin
                    mode_i = 2'b11;
                    rst_i  = 1'b0;
                    @(posedge clk_i);
                    #1;
                end
            endcase
            got = {q_o, sout_o, rise_o, fall_o, changed_o};
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL reset[%0d]: got q=%h sout=%b rise=%h fall=%h ch=%b, expected q=%h sout=%b rise=%h fall=%h ch=%b",
                         i, got[25:18], got[17], got[16:9], got[8:1], got[0],
                         ex[25:18], ex[17], ex[16:9], ex[8:1], ex[0]);
            end
        end
    endtask

    task automatic test_dload;
        step_t st[$];
        logic [25:0] got, ex;
        st.push_back(mk(1, 0, 2'b00, 8'h0F, 0, 8'h0F, 0));
        st.push_back(mk(1, 0, 2'b11, 8'h00, 0, 8'h0F, 0));
        foreach (st[i]) begin
            expect_out(st[i].q, st[i].so);
            cyc(st[i]);
            got = {q_o, sout_o, rise_o, fall_o, changed_o};
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL dload[%0d]: got q=%h sout=%b rise=%h fall=%h ch=%b, expected q=%h sout=%b rise=%h fall=%h ch=%b",
                         i, got[25:18], got[17], got[16:9], got[8:1], got[0],
                         ex[25:18], ex[17], ex[16:9], ex[8:1], ex[0]);
            end
        end
    endtask

    task automatic test_toggle;
        step_t st[$];
        logic [25:0] got, ex;
        st.push_back(mk(1, 0, 2'b01, 8'hFF, 0, 8'hF0, 0));
        st.push_back(mk(1, 0, 2'b01, 8'hFF, 0, 8'h0F, 0));
        st.push_back(mk(1, 0, 2'b01, 8'h00, 0, 8'h0F, 0));
        foreach (st[i]) begin
            expect_out(st[i].q, st[i].so);
            cyc(st[i]);
            got = {q_o, sout_o, rise_o, fall_o, changed_o};
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL toggle[%0d]: got q=%h sout=%b rise=%h fall=%h ch=%b, expected q=%h sout=%b rise=%h fall=%h ch=%b",
                         i, got[25:18], got[17], got[16:9], got[8:1], got[0],
                         ex[25:18], ex[17], ex[16:9], ex[8:1], ex[0]);
            end
        end
    endtask

    task automatic test_shift;
        step_t st[$];
        logic [25:0] got, ex;
        logic [7:0] qs[8] = '{8'h05, 8'h0B, 8'h17, 8'h2F,
                              8'h5F, 8'hBF, 8'h7F, 8'hFF};
        logic       ss[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        st.push_back(mk(1, 0, 2'b00, 8'h81, 0, 8'h81, 0));
        st.push_back(mk(1, 0, 2'b10, 8'h00, 0, 8'h02, 1));
        for (int k = 0; k < 8; k++)
            st.push_back(mk(1, 0, 2'b10, 8'h00, 1, qs[k], ss[k]));
        foreach (st[i]) begin
            expect_out(st[i].q, st[i].so);
            cyc(st[i]);
            got = {q_o, sout_o, rise_o, fall_o, changed_o};
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL shift[%0d]: got q=%h sout=%b rise=%h fall=%h ch=%b, expected q=%h sout=%b rise=%h fall=%h ch=%b",
                         i, got[25:18], got[17], got[16:9], got[8:1], got[0],
                         ex[25:18], ex[17], ex[16:9], ex[8:1], ex[0]);
            end
        end
    endtask

    task automatic test_priority;
        step_t st[$];
        logic [25:0] got, ex;
        st.push_back(mk(1, 0, 2'b10, 8'h00, 0, 8'hFE, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h3C, 0, 8'h3C, 1));
        st.push_back(mk(1, 1, 2'b10, 8'h00, 1, 8'hA5, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h3C, 0, 8'h3C, 1));
        st.push_back(mk(0, 1, 2'b00, 8'h00, 0, 8'h3C, 1));
        st.push_back(mk(0, 0, 2'b10, 8'h00, 0, 8'h3C, 1));
        foreach (st[i]) begin
            expect_out(st[i].q, st[i].so);
            cyc(st[i]);
            got = {q_o, sout_o, rise_o, fall_o, changed_o};
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL priority[%0d]: got q=%h sout=%b rise=%h fall=%h ch=%b, expected q=%h sout=%b rise=%h fall=%h ch=%b",
                         i, got[25:18], got[17], got[16:9], got[8:1], got[0],
                         ex[25:18], ex[17], ex[16:9], ex[8:1], ex[0]);
            end
        end
    endtask

    task automatic test_reset_mid_shift;
        step_t st[$];
        logic [25:0] got, ex;
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 8'h00, 1));
        st.push_back(mk(1, 0, 2'b10, 8'h00, 1, 8'h01, 0));
        st.push_back(mk(1, 0, 2'b10, 8'h00, 1, 8'h03, 0));
        st.push_back(mk(1, 0, 2'b10, 8'h00, 1, 8'hA5, 0));
        st.push_back(mk(1, 0, 2'b10, 8'h00, 1, 8'hA5, 0));
        st.push_back(mk(1, 0, 2'b10, 8'h00, 1, 8'h4B, 1));
        st.push_back(mk(1, 0, 2'b10, 8'h00, 1, 8'h97, 0));
        foreach (st[i]) begin
            case (i)
                3: begin
                    @(negedge clk_i);
                    rst_i    = 1'b1;
                    exp_prev = 8'hA5;
                    expect_out(st[i].q, st[i].so);
                    #1;
                end
                5: begin
                    @(negedge clk_i);
                    rst_i = 1'b0;
                    expect_out(st[i].q, st[i].so);
                    cyc(st[i]);
                end
                default: begin
                    expect_out(st[i].q, st[i].so);
                    cyc(st[i]);
                end
            endcase
            got = {q_o, sout_o, rise_o, fall_o, changed_o};
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL midrst[%0d]: got q=%h sout=%b rise=%h fall=%h ch=%b, expected q=%h sout=%b rise=%h fall=%h ch=%b",
                         i, got[25:18], got[17], got[16:9], got[8:1], got[0],
                         ex[25:18], ex[17], ex[16:9], ex[8:1], ex[0]);
            end
        end
    endtask

    initial begin
        rst_i  = 1'b1;
        en_i   = 1'b1;
        sclr_i = 1'b0;
        mode_i = 2'b00;
        d_i    = 8'hFF;
        sin_i  = 1'b0;
        exp_prev = 8'hA5;
        test_reset;
        test_dload;
        test_toggle;
        test_shift;
        test_priority;
        test_reset_mid_shift;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0",
                     sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/trig_reg.md
Name: trig_reg

Overview:
- Parametrised successor to the single-bit D trigger: a WIDTH-bit register bank with four per-cycle modes (D load, T toggle, serial shift, hold).
- Adds clock enable, synchronous clear, a configurable reset value, a serial in/out port and per-bit rise/fall edge flags.
- Used as the general-purpose state element for lab datapaths, in place of individual single-bit triggers.

Parameters:
- WIDTH, 8, number of register bits (>=2).
- RST_VAL, 0, value loaded into q on async reset (WIDTH bits).
- SHIFT_DIR, 0, shift direction: 0 = toward MSB (sin enters bit 0), 1 = toward LSB (sin enters bit WIDTH-1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  clock enable; 0 = hold every register.
- sclr  in  1  synchronous clear to RST_VAL; valid only while en=1.
- mode  in  2  00 = D load, 01 = T toggle, 10 = shift, 11 = hold.
- d  in  WIDTH  load data (mode 00) or toggle mask (mode 01).
- sin  in  1  serial input (mode 10).
- q  out  WIDTH  register contents.
- sout  out  1  last bit shifted out (registered).
- rise  out  WIDTH  per-bit flag: q[i] went 0->1 on the most recent clock edge.
- fall  out  WIDTH  per-bit flag: q[i] went 1->0 on the most recent clock edge.
- changed  out  1  OR-reduction of (rise | fall).

Behaviour:
- Reset (rst=1, asynchronous, takes effect without a clock edge):
  - q = RST_VAL, q_prev = RST_VAL, sout = 0.
  - Therefore rise = 0, fall = 0, changed = 0.
  - Deassertion is sampled on the next rising edge of clk; no update occurs while rst=1.
- Priority on each rising edge of clk: rst > en=0 (hold) > sclr > mode.
- en=0: q and sout hold. q_prev is still loaded with q, so rise, fall and changed drop to 0 one cycle later.
- sclr=1 with en=1: q <= RST_VAL; sout holds; mode and d are ignored.
- mode 00: q <= d.
- mode 01: q <= q ^ d (bits with d[i]=1 toggle).
- mode 10, SHIFT_DIR=0: q <= {q[WIDTH-2:0], sin}; sout <= q[WIDTH-1].
- mode 10, SHIFT_DIR=1: q <= {sin, q[WIDTH-1:1]}; sout <= q[0].
- mode 11: q holds.
- sout changes only on cycles that perform a shift.
- Edge flags:
  - q_prev <= q on every un-reset clock edge.
  - rise = q & ~q_prev; fall = ~q & q_prev.
  - These are combinational from two registers, so glitch-free.
  - A flag is high for exactly one cycle after the edge that changed the bit, unless the bit changes again on the next edge.
- Latency: 1 clock from input to q; edge flags are valid in the same cycle as the new q.
- Simultaneous events:
  - sclr together with mode 10: clear wins and sout does not update.
  - en=0 together with sclr: hold; sclr has no effect.
- Reset mid-operation: asserting rst during a shift sequence aborts it immediately. q = RST_VAL and sout = 0 with no clock edge required.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset: WIDTH=8, RST_VAL=8'hA5; assert rst between clock edges -> q=8'hA5 immediately, sout=0, rise=fall=0, changed=0.
- D load and edges: mode 00, d=8'h0F from q=8'hA5, one edge -> q=8'h0F, rise=8'h0A, fall=8'hA0, changed=1; hold one more edge -> rise=fall=0, changed=0.
- Toggle: q=8'h0F, mode 01, d=8'hFF, two edges -> q=8'hF0 then q=8'h0F; d=8'h00 -> q unchanged and changed=0.
- Shift, SHIFT_DIR=0: q=8'h81, sin=0, mode 10, one edge -> q=8'h02, sout=1; with sin=1 for 8 further edges -> q=8'hFF, sout sequence 0,0,0,0,0,0,1,0.
- Priority: en=1, sclr=1, mode 10, q=8'h3C -> q=8'hA5 and sout unchanged. en=0, sclr=1, mode 00, d=8'h00 -> q holds.
- Reset mid-shift: assert rst halfway through a 4-edge shift from q=8'h00 with sin=1 -> q=8'hA5 and sout=0 asynchronously; after release, the first edge resumes normal operation.
